compass_pwm_gen: RTL

- Avalon-MM slave that generates the heading PWM signal consumed by the compass capture input of the boat SoC.
- This is the transmitter end of the compass interface. It emulates the compass sensor so that the heading acquisition path and autopilot firmware can be exercised on the board without the physical sensor.
- The CPU writes a heading in degrees. The block emits frames: a high pulse of (BASE_TICKS + heading) ticks, followed by LOW_TICKS ticks low.

---
 rtl/compass_pwm_gen.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/compass_pwm_gen.sv
// ---------------------------------------------------------------------------
// compass_pwm_gen
//
// Compass sensor emulator. It drives the heading PWM waveform that the SoC's
// compass capture input expects, so the acquisition path and autopilot
// firmware can run on the board without the physical sensor.
//
// Each frame is a high pulse of (BASE_TICKS + H) ticks followed by LOW_TICKS
// ticks low. H is the heading in degrees (0..359) latched at frame start.
// One tick is PRESCALE clk cycles.
//
// Ports:
//   clk_clk         system clock, rising edge
//   reset_reset     asynchronous active-high reset
//   avs_address     register index (0 CTRL, 1 HEADING, 2 STATUS, 3 reserved)
//   avs_chipselect  slave select
//   avs_write_n     active-low write strobe (qualified by chipselect)
//   avs_read_n      active-low read strobe (qualified by chipselect)
//   avs_writedata   write data
//   avs_readdata    registered read data, latency 1, holds between reads
//   pwm_o           compass PWM output
//   frame_done_o    one-cycle pulse at the end of every frame
//
// Handshake: the Avalon-MM slave has no wait states. A write is accepted on
// every rising edge where chipselect & !write_n. A read is accepted on every
// rising edge where chipselect & !read_n, and avs_readdata carries the
// result from that edge onward until the next accepted read.
//
// Register map:
//   CTRL    bit0 EN, bit1 ONESHOT
//   HEADING bits[8:0], writes above 359 are clamped to 359
//   STATUS  bit0 BUSY, bit1 PHASE (1 = HIGH), bits[31:16] frame count (RO)
// ---------------------------------------------------------------------------
module compass_pwm_gen #(
  parameter int unsigned PRESCALE   = 5000,
  parameter int unsigned BASE_TICKS = 10,
  parameter int unsigned LOW_TICKS  = 650
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_write_n,
  input  logic        avs_read_n,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        pwm_o,
  output logic        frame_done_o
);

  localparam int unsigned MAX_HEADING = 359;
  localparam int unsigned MAX_HIGH    = BASE_TICKS + MAX_HEADING;
  localparam int unsigned MAX_TICKS   = (MAX_HIGH > LOW_TICKS) ? MAX_HIGH : LOW_TICKS;
  localparam int unsigned TW          = $clog2(MAX_TICKS + 1);
  localparam int unsigned PW          = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_HEADING = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;

  // Register state
  logic          en_q,        en_d;
  logic          oneshot_q,   oneshot_d;
  logic [8:0]    heading_q,   heading_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [31:0]   readdata_q,  readdata_d;

  // Frame generator state
  logic [1:0]    state_q,     state_d;
  logic [PW-1:0] presc_q,     presc_d;
  logic [TW-1:0] ticks_q,     ticks_d;
  logic          pwm_q,       pwm_d;
  logic          done_q,      done_d;

  logic          wr_en;
  logic          rd_en;
  logic          tick;
  logic [31:0]   rd_mux;

  assign wr_en = avs_chipselect & ~avs_write_n;
  assign rd_en = avs_chipselect & ~avs_read_n;

  // The prescaler only runs inside a frame, so every frame starts on a
  // fresh tick boundary and the frame length is an exact tick multiple.
  assign tick = (state_q != ST_IDLE) && (presc_q == PW'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q;
    if (state_q == ST_IDLE) begin
      presc_d = '0;
    end else if (tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Register writes and the frame FSM share one block: the FSM needs the
  // post-write heading (a write on the latch edge wins) and may clear EN
  // at the end of a one-shot frame.
  always_comb begin
    en_d        = en_q;
    oneshot_d   = oneshot_q;
    heading_d   = heading_q;
    frame_cnt_d = frame_cnt_q;
    state_d     = state_q;
    ticks_d     = ticks_q;
    done_d      = 1'b0;

    if (wr_en && (avs_address == ADDR_CTRL)) begin
      en_d      = avs_writedata[0];
      oneshot_d = avs_writedata[1];
    end
    if (wr_en && (avs_address == ADDR_HEADING)) begin
      if (avs_writedata > 32'(MAX_HEADING)) begin
        heading_d = 9'(MAX_HEADING);
      end else begin
        heading_d = avs_writedata[8:0];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (en_q) begin
          state_d = ST_HIGH;
          ticks_d = TW'(BASE_TICKS) + TW'(heading_d);
        end
      end

      ST_HIGH: begin
        if (tick) begin
          // Leaving on the tick that would take the count to zero keeps
          // the high phase at exactly count * PRESCALE cycles.
          if (ticks_q <= TW'(1)) begin
            state_d = ST_LOW;
            ticks_d = TW'(LOW_TICKS);
          end else begin
            ticks_d = ticks_q - TW'(1);
          end
        end
      end

      ST_LOW: begin
        if (tick) begin
          if (ticks_q <= TW'(1)) begin
            done_d      = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (oneshot_q) begin
              en_d    = 1'b0;
              state_d = ST_IDLE;
              ticks_d = '0;
            end else if (en_q) begin
              state_d = ST_HIGH;
              ticks_d = TW'(BASE_TICKS) + TW'(heading_d);
            end else begin
              state_d = ST_IDLE;
              ticks_d = '0;
            end
          end else begin
            ticks_d = ticks_q - TW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        ticks_d = '0;
      end
    endcase
  end

  // pwm_o follows the HIGH state one cycle later, from a flop so the pin
  // is glitch-free.
  assign pwm_d = (state_q == ST_HIGH);

  always_comb begin
    rd_mux = 32'd0;
    case (avs_address)
      ADDR_CTRL:    rd_mux = {30'd0, oneshot_q, en_q};
      ADDR_HEADING: rd_mux = {23'd0, heading_q};
      ADDR_STATUS:  rd_mux = {frame_cnt_q, 14'd0, (state_q == ST_HIGH),
                              (state_q != ST_IDLE)};
      default:      rd_mux = 32'd0;
    endcase
  end

  assign readdata_d = rd_en ? rd_mux : readdata_q;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      en_q        <= 1'b0;
      oneshot_q   <= 1'b0;
      heading_q   <= 9'd0;
      frame_cnt_q <= 16'd0;
      readdata_q  <= 32'd0;
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      ticks_q     <= '0;
      pwm_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      en_q        <= en_d;
      oneshot_q   <= oneshot_d;
      heading_q   <= heading_d;
      frame_cnt_q <= frame_cnt_d;
      readdata_q  <= readdata_d;
      state_q     <= state_d;
      presc_q     <= presc_d;
      ticks_q     <= ticks_d;
      pwm_q       <= pwm_d;
      done_q      <= done_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign pwm_o        = pwm_q;
  assign frame_done_o = done_q;

endmodule
